// File: rtl/controller_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : controller_conditioner_if
// Description : Bridge-side controller buses and conditioned core-side outputs.
// Revision    : 1.0  initial release
// ============================================================================
interface controller_conditioner_if #(
   parameter int NUM_CTRL = 4,
   parameter int BTN_W    = 16
);
   logic [NUM_CTRL*32-1:0]    key_in;
   logic [NUM_CTRL*32-1:0]    joy_in;
   logic [NUM_CTRL*16-1:0]    trig_in;
   logic [NUM_CTRL*BTN_W-1:0] btn_state;
   logic [NUM_CTRL*BTN_W-1:0] btn_press;
   logic [NUM_CTRL*BTN_W-1:0] btn_release;
   logic [NUM_CTRL*BTN_W-1:0] btn_repeat;
   logic [NUM_CTRL*32-1:0]    joy_out;
   logic [NUM_CTRL*16-1:0]    trig_out;
   logic [NUM_CTRL*4-1:0]     ctrl_type;
   logic                      sample_tick;

   modport master (
      output key_in, joy_in, trig_in,
      input  btn_state, btn_press, btn_release, btn_repeat,
      input  joy_out, trig_out, ctrl_type, sample_tick
   );

   modport slave (
      input  key_in, joy_in, trig_in,
      output btn_state, btn_press, btn_release, btn_repeat,
      output joy_out, trig_out, ctrl_type, sample_tick
   );
endinterface
`default_nettype wire

// File: rtl/controller_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : controller_conditioner
// Description : Synchronises controller inputs, debounces buttons with press/
//               release pulses, applies stick deadzone. AUTO_REPEAT_EN adds
//               held-button auto-repeat pulses.
// Revision    : 1.0  initial release
// ============================================================================
module controller_conditioner #(
   parameter int NUM_CTRL       = 4,
   parameter int BTN_W          = 16,
   parameter int TICK_DIV       = 1024,
   parameter int DEBOUNCE_TICKS = 3,
   parameter int DEADZONE       = 8
) (
   input  wire logic               clk,
   input  wire logic               reset_n,
   controller_conditioner_if.slave bus
);
   localparam int                c_nbits    = NUM_CTRL * BTN_W;
   localparam int                c_kw       = BTN_W + 4;
   localparam int                c_divw     = $clog2(TICK_DIV);
   localparam logic [c_divw-1:0] c_div_last = c_divw'(TICK_DIV - 1);
   localparam logic [3:0]        c_deb_last = 4'(DEBOUNCE_TICKS - 1);
   localparam logic [7:0]        c_deadzone = 8'(DEADZONE);

   // Only button and type bits are synchronised; the rest of key_t is ignored.
   logic                       w_unused;
   logic [NUM_CTRL*c_kw-1:0]   w_key_used, r_key_s1, r_key_s2;
   logic [NUM_CTRL*32-1:0]     r_joy_s1, r_joy_s2, w_joy_dz, r_joy_out;
   logic [NUM_CTRL*16-1:0]     r_trig_s1, r_trig_s2, r_trig_out;
   logic [NUM_CTRL*4-1:0]      w_type_s2, r_type;
   logic [c_nbits-1:0]         w_raw, w_state, w_press, w_release, w_repeat;
   logic [c_divw-1:0]          r_div;
   logic                       w_tick;

   assign w_unused = ^bus.key_in;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_div <= '0;
      end else if (w_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + c_divw'(1);
      end
   end

   assign w_tick = (r_div == c_div_last);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_key_s1   <= '0;
         r_key_s2   <= '0;
         r_joy_s1   <= '0;
         r_joy_s2   <= '0;
         r_trig_s1  <= '0;
         r_trig_s2  <= '0;
         r_joy_out  <= '0;
         r_trig_out <= '0;
         r_type     <= '0;
      end else begin
         r_key_s1   <= w_key_used;
         r_key_s2   <= r_key_s1;
         r_joy_s1   <= bus.joy_in;
         r_joy_s2   <= r_joy_s1;
         r_trig_s1  <= bus.trig_in;
         r_trig_s2  <= r_trig_s1;
         r_joy_out  <= w_joy_dz;
         r_trig_out <= r_trig_s2;
         r_type     <= w_type_s2;
      end
   end

   for (genvar i = 0; i < NUM_CTRL; i++) begin : g_slot
      assign w_key_used[c_kw*i +: c_kw] = {bus.key_in[32*i+28 +: 4], bus.key_in[32*i +: BTN_W]};
      assign w_type_s2[4*i +: 4]        = r_key_s2[c_kw*i+BTN_W +: 4];
      assign w_raw[BTN_W*i +: BTN_W]    = r_key_s2[c_kw*i +: BTN_W];

      for (genvar a = 0; a < 4; a++) begin : g_axis
         logic [7:0] w_s;
         logic [7:0] w_mag;
         // Recentre by flipping the MSB; magnitude of -128 fits unsigned 8b.
         assign w_s   = r_joy_s2[32*i+8*a +: 8] ^ 8'h80;
         assign w_mag = w_s[7] ? (~w_s + 8'd1) : w_s;
         assign w_joy_dz[32*i+8*a +: 8] = (w_mag <= c_deadzone) ? 8'h00 : w_s;
      end
   end

   for (genvar j = 0; j < c_nbits; j++) begin : g_bit
      logic [3:0] r_cnt;
      logic [3:0] w_cnt_nxt;
      logic       r_state;
      logic       r_press;
      logic       r_release;
      logic       w_flip;

      always_comb begin
         w_cnt_nxt = r_cnt;
         w_flip    = 1'b0;
         if (w_tick) begin
            if (w_raw[j] == r_state) begin
               w_cnt_nxt = '0;
            end else if (r_cnt >= c_deb_last) begin
               w_flip    = 1'b1;
               w_cnt_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_cnt     <= '0;
            r_state   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
         end else begin
            r_cnt     <= w_cnt_nxt;
            r_state   <= r_state ^ w_flip;
            r_press   <= w_flip & ~r_state;
            r_release <= w_flip & r_state;
         end
      end

      assign w_state[j]   = r_state;
      assign w_press[j]   = r_press;
      assign w_release[j] = r_release;

`ifdef AUTO_REPEAT_EN
      logic [7:0] r_rc;
      logic       r_repeat;

      // First repeat at 24 held ticks, then reload so it refires every 6.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_rc     <= '0;
            r_repeat <= 1'b0;
         end else begin
            r_repeat <= 1'b0;
            if (w_flip) begin
               r_rc     <= '0;
               r_repeat <= ~r_state;
            end else if (w_tick && r_state) begin
               if (r_rc == 8'd23) begin
                  r_rc     <= 8'd18;
                  r_repeat <= 1'b1;
               end else begin
                  r_rc <= r_rc + 8'd1;
               end
            end
         end
      end

      assign w_repeat[j] = r_repeat;
`else
      assign w_repeat[j] = 1'b0;
`endif
   end

   assign bus.btn_state   = w_state;
   assign bus.btn_press   = w_press;
   assign bus.btn_release = w_release;
   assign bus.btn_repeat  = w_repeat;
   assign bus.joy_out     = r_joy_out;
   assign bus.trig_out    = r_trig_out;
   assign bus.ctrl_type   = r_type;
   assign bus.sample_tick = w_tick;
endmodule
`default_nettype wire

// File: tb/tb_controller_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_controller_conditioner
// Description : Randomised bench for controller_conditioner against a
//               sample-history reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_controller_conditioner;
   localparam int NC = 2;
   localparam int BW = 16;
   localparam int TD = 4;
   localparam int DB = 3;
   localparam int DZ = 8;
   localparam int NB = NC * BW;

   typedef struct packed {
      logic [NC*32-1:0] k;
      logic [NC*32-1:0] j;
      logic [NC*16-1:0] t;
   } in_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   controller_conditioner_if #(.NUM_CTRL(NC), .BTN_W(BW)) bus ();

   controller_conditioner #(
      .NUM_CTRL(NC), .BTN_W(BW), .TICK_DIV(TD), .DEBOUNCE_TICKS(DB), .DEADZONE(DZ)
   ) u_dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: input history, per-bit tick sample history, held tick count
   in_t           hq[$];
   int            e;
   bit            m_state[NB];
   bit [DB-1:0]   m_hist[NB];
   int            m_nv[NB];
   int            m_held[NB];
   logic [NB-1:0] exp_state, exp_press, exp_rel, exp_rep;
   logic [NC*32-1:0] exp_joy;
   logic [NC*16-1:0] exp_trig;
   logic [NC*4-1:0]  exp_type;
   logic             exp_tick;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      hq.delete();
      e = 0;
      for (int b = 0; b < NB; b++) begin
         m_state[b] = 1'b0;
         m_hist[b]  = '0;
         m_nv[b]    = 0;
         m_held[b]  = 0;
      end
      exp_state = '0; exp_press = '0; exp_rel = '0; exp_rep = '0;
      exp_joy = '0; exp_trig = '0; exp_type = '0; exp_tick = 1'b0;
   endtask

   task automatic model_edge();
      in_t x;
      in_t r;
      x.k = bus.key_in;
      x.j = bus.joy_in;
      x.t = bus.trig_in;
      hq.push_front(x);
      if (hq.size() > 3) void'(hq.pop_back());
      // Logic downstream of the synchroniser sees the input from two edges ago
      r = (hq.size() == 3) ? hq[2] : '0;
      e++;
      exp_press = '0; exp_rel = '0; exp_rep = '0;
      if (e % TD == 0) begin
         for (int b = 0; b < NB; b++) begin
            bit raw;
            raw = r.k[32*(b/BW) + (b%BW)];
            m_hist[b] = {m_hist[b][DB-2:0], raw};
            if (m_nv[b] < DB) m_nv[b]++;
            if (m_nv[b] >= DB && m_hist[b] == {DB{~m_state[b]}}) begin
               m_state[b] = ~m_state[b];
               m_held[b]  = 0;
               if (m_state[b]) begin
                  exp_press[b] = 1'b1;
`ifdef AUTO_REPEAT_EN
                  exp_rep[b] = 1'b1;
`endif
               end else begin
                  exp_rel[b] = 1'b1;
               end
            end else if (m_state[b]) begin
               m_held[b]++;
`ifdef AUTO_REPEAT_EN
               if (m_held[b] >= 24 && (m_held[b] - 24) % 6 == 0) exp_rep[b] = 1'b1;
`endif
            end
            exp_state[b] = m_state[b];
         end
      end
      exp_tick = (e % TD == TD - 1);
      for (int s = 0; s < NC; s++) begin
         exp_type[4*s +: 4]  = r.k[32*s+28 +: 4];
         exp_trig[16*s +: 16] = r.t[16*s +: 16];
         for (int a = 0; a < 4; a++) begin
            int v, sv, mag;
            v   = int'(r.j[32*s+8*a +: 8]);
            sv  = v - 128;
            mag = (sv < 0) ? -sv : sv;
            exp_joy[32*s+8*a +: 8] = (mag <= DZ) ? 8'h00 : 8'(sv);
         end
      end
   endtask

   task automatic compare_all();
      check("btn_state",   64'(bus.btn_state),   64'(exp_state));
      check("btn_press",   64'(bus.btn_press),   64'(exp_press));
      check("btn_release", 64'(bus.btn_release), 64'(exp_rel));
      check("btn_repeat",  64'(bus.btn_repeat),  64'(exp_rep));
      check("joy_out",     64'(bus.joy_out),     64'(exp_joy));
      check("trig_out",    64'(bus.trig_out),    64'(exp_trig));
      check("ctrl_type",   64'(bus.ctrl_type),   64'(exp_type));
      check("sample_tick", 64'(bus.sample_tick), 64'(exp_tick));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (!reset_n) model_reset();
      else model_edge();
      compare_all();
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      repeat (3) step();
      reset_n = 1'b1;
   endtask

   task automatic set_lx1(input logic [7:0] v);
      bus.joy_in[32 +: 8] = v;
      repeat (4) step();
   endtask

   initial begin
      bus.key_in  = '0;
      bus.joy_in  = {(NC*4){8'h80}};
      bus.trig_in = '0;
      model_reset();
      repeat (3) step();
      reset_n = 1'b1;
      repeat (12) step();

      // Long press and release of slot0 bit0
      bus.key_in[0] = 1'b1;
      repeat (20) step();
      bus.key_in[0] = 1'b0;
      repeat (20) step();

      // Short glitch on bit5
      bus.key_in[5] = 1'b1;
      repeat (8) step();
      bus.key_in[5] = 1'b0;
      repeat (16) step();

      // Deadzone edges on slot1 lx / ly
      set_lx1(8'h88);
      set_lx1(8'h89);
      set_lx1(8'h00);
      set_lx1(8'h80);
      bus.joy_in[40 +: 8] = 8'h77;
      repeat (4) step();
      bus.joy_in[40 +: 8] = 8'h78;
      repeat (4) step();

      // Simultaneous presses across slots, slot1 type nibble
      bus.key_in[3]      = 1'b1;
      bus.key_in[32+15]  = 1'b1;
      bus.key_in[63:60]  = 4'hA;
      bus.trig_in        = 32'h1234_abcd;
      repeat (24) step();
      bus.key_in[3]     = 1'b0;
      bus.key_in[32+15] = 1'b0;
      repeat (6) step();
      pulse_reset();
      repeat (24) step();

      // Long hold for auto-repeat
      bus.key_in[0] = 1'b1;
      repeat (TD * 45) step();
      bus.key_in[0] = 1'b0;
      repeat (24) step();

      // Random traffic
      for (int c = 0; c < 2600; c++) begin
         if ($urandom_range(0, 9) == 0) begin
            int s, b;
            s = $urandom_range(0, NC - 1);
            b = $urandom_range(0, BW - 1);
            bus.key_in[32*s+b] = ~bus.key_in[32*s+b];
         end
         if ($urandom_range(0, 39) == 0) begin
            int s;
            s = $urandom_range(0, NC - 1);
            bus.key_in[32*s+16 +: 16] = 16'($urandom);
         end
         if ($urandom_range(0, 4) == 0) begin
            for (int s = 0; s < NC; s++) begin
               for (int a = 0; a < 4; a++) begin
                  if ($urandom_range(0, 1) == 0)
                     bus.joy_in[32*s+8*a +: 8] = 8'(116 + $urandom_range(0, 24));
                  else
                     bus.joy_in[32*s+8*a +: 8] = 8'($urandom);
               end
            end
            bus.trig_in = 32'($urandom);
         end
         if (c == 1300) pulse_reset();
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
